// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier sequencer slice.
// Holds the sequencer state encoding, default parameter values, the
// widths derived from them, and a constant clog2 helper.
package mult_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_WORD_LENGTH = 4;
  localparam int unsigned DEF_FIFO_DEPTH  = 2;
  localparam int unsigned DEF_TIMEOUT     = 32;

  localparam int unsigned PROD_W = 2 * DEF_WORD_LENGTH;
  localparam int unsigned PTR_W  = clog2(DEF_FIFO_DEPTH);
  localparam int unsigned WD_W   = clog2(DEF_TIMEOUT) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StMbusy,
    StMwait,
    StAbort
  } state_e;

endpackage

// File: rtl/mult_operand_fifo.sv
// Synchronous FIFO holding packed operand pairs for the sequencer.
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   push, wdata    - write request and data (ignored while full)
//   pop            - read request; rdata shows the head entry combinationally
//   full, empty    - occupancy flags
// Full is evaluated before any same-cycle pop, so a pop never frees room for
// a write in the same cycle.
module mult_operand_fifo
  import mult_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mult_sequencer.sv
// Sequencer wrapped around a shift-add multiplier.
// Ports:
//   clk, reset                 - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_a/in_b - operand pair input handshake (buffered in a FIFO)
//   mult_a/mult_b              - operands to the multiplier, held from issue to capture
//   mult_start                 - one-cycle start pulse
//   mult_reset_sync            - one-cycle synchronous clear on watchdog abort
//   mult_ready/mult_product    - multiplier ready level and result
//   res_valid/res_ready/res_data - product output handshake
//   busy                       - work in flight or queued
//   err_timeout/err_clear      - sticky watchdog flag and its synchronous clear
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_LENGTH-1:0]   in_a,
  input  logic [WORD_LENGTH-1:0]   in_b,
  output logic [WORD_LENGTH-1:0]   mult_a,
  output logic [WORD_LENGTH-1:0]   mult_b,
  output logic                     mult_start,
  output logic                     mult_reset_sync,
  input  logic                     mult_ready,
  input  logic [2*WORD_LENGTH-1:0] mult_product,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [2*WORD_LENGTH-1:0] res_data,
  output logic                     busy,
  output logic                     err_timeout,
  input  logic                     err_clear
);

  localparam int unsigned ProdW = 2 * WORD_LENGTH;
  localparam int unsigned WdW   = clog2(TIMEOUT) + 1;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic                   res_valid_q, res_valid_d;
  logic [ProdW-1:0]       res_data_q, res_data_d;
  logic                   err_q, err_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ProdW-1:0]       fifo_rdata;
  logic [WORD_LENGTH-1:0] head_a, head_b;
  logic                   wd_expired;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign {head_a, head_b} = fifo_rdata;

  mult_operand_fifo #(
    .Width (ProdW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // This cycle is the TIMEOUT-th spent waiting on the multiplier.
  assign wd_expired = (wd_q >= WdW'(TIMEOUT - 1));

  always_comb begin
    state_d         = state_q;
    mult_a_d        = mult_a_q;
    mult_b_d        = mult_b_q;
    wd_d            = wd_q;
    res_valid_d     = res_valid_q;
    res_data_d      = res_data_q;
    err_d           = err_q;
    fifo_pop        = 1'b0;
    mult_start      = 1'b0;
    mult_reset_sync = 1'b0;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if (err_clear)                err_d       = 1'b0;

    if ((state_q == StMbusy || state_q == StMwait) && wd_q != WdW'(TIMEOUT)) begin
      wd_d = wd_q + WdW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !res_valid_q && mult_ready) begin
          fifo_pop = 1'b1;
          mult_a_d = head_a;
          mult_b_d = head_b;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        mult_start = 1'b1;
        wd_d       = '0;
        state_d    = StMbusy;
      end
      StMbusy: begin
        // Ready going low is the multiplier's acknowledgement of the start.
        if (!mult_ready)     state_d = StMwait;
        else if (wd_expired) state_d = StAbort;
      end
      StMwait: begin
        if (mult_ready) begin
          res_data_d  = mult_product;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (wd_expired) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        // A new timeout overrides a same-cycle err_clear.
        mult_reset_sync = 1'b1;
        err_d           = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      wd_q        <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
      wd_q        <= wd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule
